// File: rtl/cache_line_mover_if.sv
// Cache-side and burst-memory-side signal bundle for cache_line_mover.
// master = the line mover itself, slave = the cache controller / memory environment.
interface cache_line_mover_if #(
    parameter int LINE_WORDS_BITWIDTH = 2,
    parameter int ADDRESS_BITWIDTH    = 32
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic                           cmd_writeback;
    logic [ADDRESS_BITWIDTH-1:0]    cmd_fill_address;
    logic [ADDRESS_BITWIDTH-1:0]    cmd_evict_address;
    logic [LINE_WORDS_BITWIDTH-1:0] evict_word_ix;
    logic [31:0]                    evict_word;
    logic                           fill_write_enable;
    logic [LINE_WORDS_BITWIDTH-1:0] fill_word_ix;
    logic [31:0]                    fill_word;
    logic                           done;
    logic                           mem_cmd_valid;
    logic                           mem_cmd_ready;
    logic                           mem_cmd_write;
    logic [ADDRESS_BITWIDTH-1:0]    mem_cmd_address;
    logic                           mem_wvalid;
    logic                           mem_wready;
    logic [31:0]                    mem_wdata;
    logic                           mem_rvalid;
    logic [31:0]                    mem_rdata;

    modport master (
        input  cmd_valid, cmd_writeback, cmd_fill_address, cmd_evict_address, evict_word,
               mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata,
        output cmd_ready, evict_word_ix, fill_write_enable, fill_word_ix, fill_word, done,
               mem_cmd_valid, mem_cmd_write, mem_cmd_address, mem_wvalid, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_writeback, cmd_fill_address, cmd_evict_address, evict_word,
               mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata,
        input  cmd_ready, evict_word_ix, fill_write_enable, fill_word_ix, fill_word, done,
               mem_cmd_valid, mem_cmd_write, mem_cmd_address, mem_wvalid, mem_wdata
    );
endinterface

// File: rtl/cache_line_mover.sv
// Moves one cache line between the column RAMs and burst memory: optional dirty writeback, then fill.
// Optional: CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN starts the fill burst at the missed column.
module cache_line_mover #(
    parameter int LINE_WORDS_BITWIDTH = 2,
    parameter int ADDRESS_BITWIDTH    = 32
) (
    input  logic clk,
    input  logic rst,
    cache_line_mover_if.master bus
);
    localparam int OFFSET_BITS = LINE_WORDS_BITWIDTH + 2;
    localparam logic [LINE_WORDS_BITWIDTH:0] LAST_BEAT =
        (LINE_WORDS_BITWIDTH+1)'((1 << LINE_WORDS_BITWIDTH) - 1);
    localparam logic [LINE_WORDS_BITWIDTH-1:0] BEAT_ONE = LINE_WORDS_BITWIDTH'(1);
    localparam logic [LINE_WORDS_BITWIDTH:0]   DONE_ONE = (LINE_WORDS_BITWIDTH+1)'(1);

    typedef enum logic [2:0] {
        IDLE, WB_CMD, WB_READ, WB_BEAT, FILL_CMD, FILL_DATA, DONE
    } state_t;

    state_t                          state, state_next;
    logic [LINE_WORDS_BITWIDTH-1:0]  beat;
    logic [LINE_WORDS_BITWIDTH-1:0]  start_col;
    logic [LINE_WORDS_BITWIDTH:0]    beats_done;
    logic [ADDRESS_BITWIDTH-1:0]     evict_base;
    logic [ADDRESS_BITWIDTH-1:0]     fill_start;
    logic [31:0]                     wdata_hold;
    logic                            wdata_held;
    logic                            fill_we;
    logic [LINE_WORDS_BITWIDTH-1:0]  fill_ix;
    logic [31:0]                     fill_data;
    logic                            last_beat;

    function automatic logic [ADDRESS_BITWIDTH-1:0] line_base(input logic [ADDRESS_BITWIDTH-1:0] addr);
        return addr & ~ADDRESS_BITWIDTH'((1 << OFFSET_BITS) - 1);
    endfunction

    // The beat counter may start mid-line and wrap, so end-of-burst is counted separately.
    assign last_beat = (beats_done == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next          = state;
        bus.cmd_ready       = 1'b0;
        bus.mem_cmd_valid   = 1'b0;
        bus.mem_cmd_write   = 1'b0;
        bus.mem_cmd_address = '0;
        bus.evict_word_ix   = '0;
        bus.mem_wvalid      = 1'b0;
        bus.mem_wdata       = '0;
        bus.done            = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_next = bus.cmd_writeback ? WB_CMD : FILL_CMD;
            end
            WB_CMD: begin
                bus.mem_cmd_valid   = 1'b1;
                bus.mem_cmd_write   = 1'b1;
                bus.mem_cmd_address = evict_base;
                if (bus.mem_cmd_ready) state_next = WB_READ;
            end
            WB_READ: begin
                bus.evict_word_ix = beat;
                state_next        = WB_BEAT;
            end
            WB_BEAT: begin
                // RAM output is valid on entry; the held copy keeps the beat stable under backpressure.
                bus.mem_wvalid = 1'b1;
                bus.mem_wdata  = wdata_held ? wdata_hold : bus.evict_word;
                if (bus.mem_wready) state_next = last_beat ? FILL_CMD : WB_READ;
            end
            FILL_CMD: begin
                bus.mem_cmd_valid   = 1'b1;
                bus.mem_cmd_address = fill_start;
                if (bus.mem_cmd_ready) state_next = FILL_DATA;
            end
            FILL_DATA: begin
                if (bus.mem_rvalid && last_beat) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            start_col  <= '0;
            beats_done <= '0;
            evict_base <= '0;
            fill_start <= '0;
            wdata_hold <= '0;
            wdata_held <= 1'b0;
            fill_we    <= 1'b0;
            fill_ix    <= '0;
            fill_data  <= '0;
        end else begin
            fill_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        evict_base <= line_base(bus.cmd_evict_address);
`ifdef CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN
                        start_col  <= bus.cmd_fill_address[OFFSET_BITS-1:2];
                        fill_start <= {bus.cmd_fill_address[ADDRESS_BITWIDTH-1:2], 2'b00};
`else
                        start_col  <= '0;
                        fill_start <= line_base(bus.cmd_fill_address);
`endif
                    end
                end
                WB_CMD: begin
                    if (bus.mem_cmd_ready) begin
                        beat       <= '0;
                        beats_done <= '0;
                        wdata_held <= 1'b0;
                    end
                end
                WB_BEAT: begin
                    if (!wdata_held) begin
                        wdata_hold <= bus.evict_word;
                        wdata_held <= 1'b1;
                    end
                    if (bus.mem_wready) begin
                        beat       <= beat + BEAT_ONE;
                        beats_done <= beats_done + DONE_ONE;
                        wdata_held <= 1'b0;
                    end
                end
                FILL_CMD: begin
                    if (bus.mem_cmd_ready) begin
                        beat       <= start_col;
                        beats_done <= '0;
                    end
                end
                FILL_DATA: begin
                    if (bus.mem_rvalid) begin
                        fill_we    <= 1'b1;
                        fill_data  <= bus.mem_rdata;
                        fill_ix    <= beat;
                        beat       <= beat + BEAT_ONE;
                        beats_done <= beats_done + DONE_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fill_write_enable = fill_we;
    assign bus.fill_word_ix      = fill_ix;
    assign bus.fill_word         = fill_data;
endmodule

// File: tb/tb_cache_line_mover.sv
// Scoreboard bench for cache_line_mover: reset, plain fill, writeback+fill, backpressure,
// back-to-back commands and reset in the middle of a fill.
module tb_cache_line_mover;
    localparam int LW = 2;
    localparam int AW = 32;
    localparam int WORDS = 1 << LW;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   hold_viol = 0;
    int   busy_ready = 0;

    cache_line_mover_if #(.LINE_WORDS_BITWIDTH(LW), .ADDRESS_BITWIDTH(AW)) bus ();
    cache_line_mover #(.LINE_WORDS_BITWIDTH(LW), .ADDRESS_BITWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cache_col [WORDS];
    always @(posedge clk) bus.evict_word <= cache_col[bus.evict_word_ix];

    logic [LW+31:0] obs_fill[$], exp_fill[$];
    int             obs_fill_cyc[$], done_cyc[$];
    logic [AW:0]    obs_cmd[$], exp_cmd[$];
    logic [31:0]    obs_wdata[$], exp_wdata[$];

    always @(negedge clk) begin
        if (bus.fill_write_enable) begin
            obs_fill.push_back({bus.fill_word_ix, bus.fill_word});
            obs_fill_cyc.push_back(cyc);
        end
        if (bus.done) done_cyc.push_back(cyc);
    end

    function automatic logic [AW-1:0] exp_fill_addr(input logic [AW-1:0] a);
`ifdef CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN
        return {a[AW-1:2], 2'b00};
`else
        return a & 32'hFFFF_FFF0;
`endif
    endfunction

    function automatic logic [LW-1:0] exp_start(input logic [AW-1:0] a);
`ifdef CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN
        return a[3:2];
`else
        return a[1:0] & 2'b00;
`endif
    endfunction

    task automatic clear_queues();
        obs_fill.delete(); exp_fill.delete(); obs_fill_cyc.delete(); done_cyc.delete();
        obs_cmd.delete(); exp_cmd.delete(); obs_wdata.delete(); exp_wdata.delete();
        hold_viol = 0; busy_ready = 0;
    endtask

    task automatic start_cmd(input bit wb, input logic [AW-1:0] fa, input logic [AW-1:0] ea,
                             output int t0, output bit rdy);
        @(negedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_writeback = wb;
        bus.cmd_fill_address = fa;
        bus.cmd_evict_address = ea;
        rdy = bus.cmd_ready;
        t0 = cyc;
    endtask

    // Memory / cache-controller responder; fill expectations are pushed as beats are driven.
    task automatic mem_respond(input logic [LW-1:0] start_ix, input logic [31:0] data0,
                               input int cmd_delay, input bit toggle_w, input bit stray,
                               input bit hold_cmd, output bit timed_out);
        int rd_left;
        int wait_cnt;
        int k;
        logic [LW-1:0] ix;
        logic [AW:0] ref_cmd;
        bit have_ref;
        rd_left = 0; wait_cnt = 0; k = 0; ix = start_ix; ref_cmd = '0; have_ref = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (hold_cmd && bus.cmd_ready && !bus.done) busy_ready++;
            if (bus.mem_cmd_valid) begin
                if (have_ref && ref_cmd !== {bus.mem_cmd_write, bus.mem_cmd_address}) hold_viol++;
                ref_cmd = {bus.mem_cmd_write, bus.mem_cmd_address};
                have_ref = 1'b1;
            end
            if (bus.done) begin
                #1;
                bus.cmd_valid = 1'b0; bus.mem_rvalid = 1'b0;
                bus.mem_cmd_ready = 1'b0; bus.mem_wready = 1'b0;
                timed_out = 1'b0;
                break;
            end
            #1;
            bus.cmd_valid = hold_cmd;
            if (hold_cmd) begin
                bus.cmd_writeback = 1'b1;
                bus.cmd_fill_address = 32'h0000_7FFC;
                bus.cmd_evict_address = 32'h0000_6000;
            end
            if (rd_left > 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = data0 + 32'(k);
                exp_fill.push_back({ix, bus.mem_rdata});
                ix = ix + 1'b1;
                k++;
                rd_left--;
            end else if (stray && bus.mem_cmd_valid && !bus.mem_cmd_write) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end else begin
                bus.mem_rvalid = 1'b0;
            end
            if (bus.mem_cmd_valid) begin
                wait_cnt++;
                bus.mem_cmd_ready = (wait_cnt > cmd_delay);
            end else begin
                wait_cnt = 0;
                bus.mem_cmd_ready = 1'b0;
            end
            bus.mem_wready = toggle_w ? ((c % 2) == 1) : 1'b1;
            if (bus.mem_wvalid && bus.mem_wready) obs_wdata.push_back(bus.mem_wdata);
            if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                obs_cmd.push_back({bus.mem_cmd_write, bus.mem_cmd_address});
                have_ref = 1'b0;
                if (!bus.mem_cmd_write) rd_left = WORDS;
            end
        end
        if (timed_out) begin
            bus.cmd_valid = 1'b0;
            bus.mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_writeback = 1'b0;
        bus.cmd_fill_address = '0; bus.cmd_evict_address = '0;
        bus.mem_cmd_ready = 1'b0; bus.mem_wready = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < WORDS; i++) cache_col[i] = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
        end
        total++;
        if ({bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_address, bus.mem_wvalid, bus.mem_wdata,
             bus.fill_write_enable, bus.fill_word_ix, bus.fill_word, bus.evict_word_ix, bus.done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {bus.mem_cmd_valid, bus.mem_cmd_write,
                     bus.mem_cmd_address, bus.mem_wvalid, bus.mem_wdata, bus.fill_write_enable,
                     bus.fill_word_ix, bus.fill_word, bus.evict_word_ix, bus.done});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.mem_cmd_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset cmd_ready=%b mem_cmd_valid=%b want 1/0",
                            bus.cmd_ready, bus.mem_cmd_valid);
        end
    endtask

    task automatic test_plain_fill(input logic [AW-1:0] fa, input logic [31:0] d0);
        int t0; bit rdy; bit to;
        logic [LW+31:0] e, o;
        clear_queues();
        exp_cmd.push_back({1'b0, exp_fill_addr(fa)});
        start_cmd(1'b0, fa, 32'h0, t0, rdy);
        mem_respond(exp_start(fa), d0, 0, 1'b0, 1'b0, 1'b0, to);
        total++;
        if (rdy !== 1'b1 || to !== 1'b0) begin
            bad++; $display("FAIL fill_handshake rdy=%b timeout=%b want 1/0", rdy, to);
        end
        total++;
        if (obs_cmd.size() != 1 || obs_cmd[0] !== exp_cmd[0]) begin
            bad++; $display("FAIL fill_mem_cmd got=%h (n=%0d) want=%h", obs_cmd.size() > 0 ? obs_cmd[0] : '0,
                            obs_cmd.size(), exp_cmd[0]);
        end
        total++;
        if (obs_fill.size() != WORDS || obs_fill_cyc.size() == 0 || obs_fill_cyc[0] != t0 + 3) begin
            bad++; $display("FAIL fill_first_write count=%0d cyc=%0d want=%0d at %0d", obs_fill.size(),
                            obs_fill_cyc.size() > 0 ? obs_fill_cyc[0] - t0 : -1, WORDS, 3);
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != t0 + 6) begin
            bad++; $display("FAIL fill_done_cycle got=%0d (n=%0d) want=6",
                            done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, done_cyc.size());
        end
        while (exp_fill.size() > 0 && obs_fill.size() > 0) begin
            e = exp_fill.pop_front(); o = obs_fill.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL fill_word got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_writeback_fill();
        int t0; bit rdy; bit to;
        logic [LW+31:0] e, o;
        logic [31:0] w;
        logic [AW:0] c;
        clear_queues();
        cache_col[0] = 32'h11; cache_col[1] = 32'h22; cache_col[2] = 32'h33; cache_col[3] = 32'h44;
        for (int i = 0; i < WORDS; i++) exp_wdata.push_back(cache_col[i]);
        exp_cmd.push_back({1'b1, 32'h0000_2000});
        exp_cmd.push_back({1'b0, exp_fill_addr(32'h0000_3004)});
        start_cmd(1'b1, 32'h0000_3004, 32'h0000_2010 - 32'h10, t0, rdy);
        mem_respond(exp_start(32'h0000_3004), 32'h0000_00C0, 0, 1'b1, 1'b0, 1'b0, to);
        total++;
        if (rdy !== 1'b1 || to !== 1'b0) begin
            bad++; $display("FAIL wb_handshake rdy=%b timeout=%b want 1/0", rdy, to);
        end
        total++;
        if (obs_wdata.size() != WORDS || obs_cmd.size() != 2) begin
            bad++; $display("FAIL wb_counts beats=%0d cmds=%0d want 4/2", obs_wdata.size(), obs_cmd.size());
        end
        total++;
        if (done_cyc.size() != 1 || obs_fill_cyc.size() != WORDS || done_cyc[0] != obs_fill_cyc[WORDS-1]) begin
            bad++; $display("FAIL wb_done_after_fills dones=%0d fills=%0d want 1/4 aligned",
                            done_cyc.size(), obs_fill_cyc.size());
        end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            c = obs_cmd.pop_front();
            total++;
            if (c !== exp_cmd[0]) begin bad++; $display("FAIL wb_mem_cmd got=%h want=%h", c, exp_cmd[0]); end
            void'(exp_cmd.pop_front());
        end
        while (exp_wdata.size() > 0 && obs_wdata.size() > 0) begin
            w = obs_wdata.pop_front();
            total++;
            if (w !== exp_wdata[0]) begin bad++; $display("FAIL wb_beat got=%h want=%h", w, exp_wdata[0]); end
            void'(exp_wdata.pop_front());
        end
        while (exp_fill.size() > 0 && obs_fill.size() > 0) begin
            e = exp_fill.pop_front(); o = obs_fill.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL wb_fill_word got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        int t0; bit rdy; bit to;
        logic [LW+31:0] e, o;
        clear_queues();
        start_cmd(1'b0, 32'h0000_1238, 32'h0, t0, rdy);
        mem_respond(exp_start(32'h0000_1238), 32'h0000_00B0, 5, 1'b0, 1'b1, 1'b1, to);
        total++;
        if (to !== 1'b0 || hold_viol != 0) begin
            bad++; $display("FAIL bp_cmd_hold timeout=%b changes=%0d want 0/0", to, hold_viol);
        end
        total++;
        if (busy_ready != 0) begin
            bad++; $display("FAIL bp_cmd_ready_busy got=%0d cycles want=0", busy_ready);
        end
        total++;
        if (obs_cmd.size() != 1 || obs_cmd[0] !== {1'b0, exp_fill_addr(32'h0000_1238)}) begin
            bad++; $display("FAIL bp_mem_cmd n=%0d want 1 read to %h", obs_cmd.size(), exp_fill_addr(32'h0000_1238));
        end
        total++;
        if (obs_fill.size() != WORDS || done_cyc.size() != 1 || done_cyc[0] != t0 + 11) begin
            bad++; $display("FAIL bp_fill_timing fills=%0d dones=%0d done_at=%0d want 4/1/11", obs_fill.size(),
                            done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t0 : -1);
        end
        while (exp_fill.size() > 0 && obs_fill.size() > 0) begin
            e = exp_fill.pop_front(); o = obs_fill.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL bp_fill_word got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1; bit rdy0, rdy1, to0, to1;
        int first_done;
        logic [LW+31:0] e, o;
        clear_queues();
        start_cmd(1'b0, 32'h0000_0040, 32'h0, t0, rdy0);
        mem_respond(exp_start(32'h0000_0040), 32'h0000_00C8, 0, 1'b0, 1'b0, 1'b0, to0);
        first_done = (done_cyc.size() > 0) ? done_cyc[0] : -100;
        start_cmd(1'b0, 32'h0000_0088, 32'h0, t1, rdy1);
        mem_respond(exp_start(32'h0000_0088), 32'h0000_00D0, 0, 1'b0, 1'b0, 1'b0, to1);
        total++;
        if (rdy1 !== 1'b1 || t1 != first_done + 1) begin
            bad++; $display("FAIL b2b_accept ready=%b gap=%0d want 1/1", rdy1, t1 - first_done);
        end
        total++;
        if (to0 || to1 || done_cyc.size() != 2 || obs_fill.size() != 2 * WORDS) begin
            bad++; $display("FAIL b2b_counts dones=%0d fills=%0d want 2/8", done_cyc.size(), obs_fill.size());
        end
        total++;
        if (obs_cmd.size() != 2 || obs_cmd[1] !== {1'b0, exp_fill_addr(32'h0000_0088)}) begin
            bad++; $display("FAIL b2b_second_cmd n=%0d want read to %h", obs_cmd.size(), exp_fill_addr(32'h0000_0088));
        end
        while (exp_fill.size() > 0 && obs_fill.size() > 0) begin
            e = exp_fill.pop_front(); o = obs_fill.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b_fill_word got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int t0; bit rdy;
        clear_queues();
        start_cmd(1'b0, 32'h0000_1238, 32'h0, t0, rdy);
        @(negedge clk); #1 bus.cmd_valid = 1'b0; bus.mem_cmd_ready = 1'b1;
        @(negedge clk); #1 bus.mem_cmd_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hE0;
        @(negedge clk); #1 bus.mem_rdata = 32'hE1;
        @(negedge clk); #1 bus.mem_rvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 ||
            {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_address, bus.mem_wvalid, bus.mem_wdata,
             bus.fill_write_enable, bus.fill_word_ix, bus.fill_word, bus.evict_word_ix, bus.done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs cmd_ready=%b rest=%h want 1/0", bus.cmd_ready,
                     {bus.mem_cmd_valid, bus.mem_cmd_address, bus.mem_wvalid, bus.fill_write_enable,
                      bus.fill_word_ix, bus.fill_word, bus.done});
        end
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (done_cyc.size() != 0 || obs_fill.size() != 2) begin
            bad++; $display("FAIL midreset_no_done dones=%0d fills=%0d want 0/2", done_cyc.size(), obs_fill.size());
        end
        test_plain_fill(32'h0000_5014, 32'h0000_00F0);
    endtask

    initial begin
        test_reset();
        test_plain_fill(32'h0000_1238, 32'h0000_00A0);
        test_writeback_fill();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
